// File: rtl/nou_wr_arb_pkg.sv
// Shared definitions for the NoU write-path arbiter.
//   - Packet size field widths used to derive the default flit-count widths.
//   - Default response timeout.
//   - Arbiter FSM state encoding.
//   - Modulo-N increment helper for round-robin pointers.
package nou_wr_arb_pkg;

   localparam int unsigned NouPktHeaderSzWidth = 8;
   localparam int unsigned NouPktDataSzWidth   = 8;

   localparam int unsigned HdrWDefault = NouPktHeaderSzWidth + 1 - 6;
   localparam int unsigned DatWDefault = NouPktDataSzWidth + 4;
   localparam int unsigned TmoDefault  = 1024;

   typedef enum logic [1:0] {
      StIdle,
      StStart,
      StWait
   } wr_arb_state_e;

   // (i + 1) mod n, for i < n
   function automatic int unsigned wrap_inc(input int unsigned i, input int unsigned n);
      return (i + 1 >= n) ? 0 : i + 1;
   endfunction

endpackage

// File: rtl/nou_rr_arb.sv
// Combinational round-robin picker.
//   req     : request vector
//   ptr     : highest-priority index this round
//   win     : one-hot winner (zero when no request)
//   win_idx : binary index of the winner
//   valid   : at least one request present
module nou_rr_arb #(
   parameter int unsigned NREQ  = 4,
   parameter int unsigned IDX_W = $clog2(NREQ)
) (
   input  logic [NREQ-1:0]  req,
   input  logic [IDX_W-1:0] ptr,
   output logic [NREQ-1:0]  win,
   output logic [IDX_W-1:0] win_idx,
   output logic             valid
);

   always_comb begin
      int unsigned c;
      c       = 0;
      win     = '0;
      win_idx = '0;
      valid   = 1'b0;
      // Scan from ptr upward, wrapping; the first hit wins.
      for (int unsigned i = 0; i < NREQ; i++) begin
         c = 32'(ptr) + i;
         if (c >= NREQ) begin
            c = c - NREQ;
         end
         if (!valid && req[c]) begin
            valid   = 1'b1;
            win[c]  = 1'b1;
            win_idx = c[IDX_W-1:0];
         end
      end
   end

endmodule

// File: rtl/nou_wr_arb_ctl.sv
// Write-path arbiter: grants one of NREQ requesters the shared AXI write engine,
// hands the latched flit counts to the engine, and returns done/err from the
// B-channel controller (or a timeout error) to the granted requester.
//   clk, rstn            : clock, synchronous active-low reset
//   req                  : per-requester request, held until gnt
//   req_hdr_num/dat_num  : per-requester header / data flit counts
//   gnt, done, err       : one-hot, one-cycle pulses to the requesters
//   wr_start             : one-cycle start pulse to the write engine
//   wr_hdr_num/dat_num   : latched counts, stable for the whole transaction
//   wr_done, wr_err      : B-channel result, honoured only while waiting
//   tmo_flag             : sticky timeout status
module nou_wr_arb_ctl
   import nou_wr_arb_pkg::*;
#(
   parameter int unsigned NREQ  = 4,
   parameter int unsigned HDR_W = HdrWDefault,
   parameter int unsigned DAT_W = DatWDefault,
   parameter int unsigned TMO   = TmoDefault
) (
   input  logic                        clk,
   input  logic                        rstn,
   input  logic [NREQ-1:0]             req,
   input  logic [NREQ-1:0][HDR_W-1:0]  req_hdr_num,
   input  logic [NREQ-1:0][DAT_W-1:0]  req_dat_num,
   output logic [NREQ-1:0]             gnt,
   output logic [NREQ-1:0]             done,
   output logic [NREQ-1:0]             err,
   output logic                        wr_start,
   output logic [HDR_W-1:0]            wr_hdr_num,
   output logic [DAT_W-1:0]            wr_dat_num,
   input  logic                        wr_done,
   input  logic                        wr_err,
   output logic                        tmo_flag
);

   localparam int unsigned IDX_W = $clog2(NREQ);
   localparam int unsigned TMR_W = $clog2(TMO);

   wr_arb_state_e state_q, state_d;

   logic [IDX_W-1:0] idx_q;
   logic [NREQ-1:0]  oh_q;
   logic [HDR_W-1:0] hdr_q;
   logic [DAT_W-1:0] dat_q;
   logic [IDX_W-1:0] rr_ptr_q;
   logic [TMR_W-1:0] timer_q;
   logic             tmo_flag_q;

   logic [NREQ-1:0]  arb_win;
   logic [IDX_W-1:0] arb_idx;
   logic             arb_valid;

   logic [DAT_W:0]   cnt_sum;
   logic             zero_cnt;
   logic             tmo_hit;
   logic             wait_exit;
   logic [IDX_W-1:0] idx_inc;

   nou_rr_arb #(
      .NREQ  (NREQ),
      .IDX_W (IDX_W)
   ) u_rr_arb (
      .req     (req),
      .ptr     (rr_ptr_q),
      .win     (arb_win),
      .win_idx (arb_idx),
      .valid   (arb_valid)
   );

   // Extra bit keeps the sum from wrapping to zero on maximal counts.
   assign cnt_sum   = {1'b0, dat_q} + (DAT_W + 1)'(hdr_q);
   assign zero_cnt  = (cnt_sum == '0);
   assign tmo_hit   = (timer_q == TMR_W'(TMO - 1));
   assign wait_exit = wr_err | wr_done | tmo_hit;
   assign idx_inc   = IDX_W'(wrap_inc(32'(idx_q), NREQ));

   // State register
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (arb_valid) state_d = StStart;
         StStart: state_d = zero_cnt ? StIdle : StWait;
         StWait:  if (wait_exit) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Transaction context, round-robin pointer, timer and sticky timeout flag
   always_ff @(posedge clk) begin
      if (!rstn) begin
         idx_q      <= '0;
         oh_q       <= '0;
         hdr_q      <= '0;
         dat_q      <= '0;
         rr_ptr_q   <= '0;
         timer_q    <= '0;
         tmo_flag_q <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               timer_q <= '0;
               if (arb_valid) begin
                  idx_q <= arb_idx;
                  oh_q  <= arb_win;
                  hdr_q <= req_hdr_num[arb_idx];
                  dat_q <= req_dat_num[arb_idx];
               end
            end
            StStart: begin
               timer_q <= '0;
               if (zero_cnt) begin
                  rr_ptr_q <= idx_inc;
               end
            end
            StWait: begin
               if (wait_exit) begin
                  timer_q  <= '0;
                  rr_ptr_q <= idx_inc;
                  if (!wr_err && !wr_done) begin
                     tmo_flag_q <= 1'b1;
                  end
               end else begin
                  timer_q <= timer_q + 1'b1;
               end
            end
            default: timer_q <= '0;
         endcase
      end
   end

   // Outputs; forced low while rstn is asserted, even before the reset edge.
   always_comb begin
      gnt        = '0;
      done       = '0;
      err        = '0;
      wr_start   = 1'b0;
      wr_hdr_num = '0;
      wr_dat_num = '0;
      unique case (state_q)
         StIdle: ;
         StStart: begin
            gnt        = oh_q;
            wr_hdr_num = hdr_q;
            wr_dat_num = dat_q;
            if (zero_cnt) begin
               err = oh_q;
            end else begin
               wr_start = 1'b1;
            end
         end
         StWait: begin
            wr_hdr_num = hdr_q;
            wr_dat_num = dat_q;
            // err takes priority over done; timeout reports as err.
            if (wr_err || (tmo_hit && !wr_done)) begin
               err = oh_q;
            end else if (wr_done) begin
               done = oh_q;
            end
         end
         default: ;
      endcase
      if (!rstn) begin
         gnt        = '0;
         done       = '0;
         err        = '0;
         wr_start   = 1'b0;
         wr_hdr_num = '0;
         wr_dat_num = '0;
      end
   end

   assign tmo_flag = tmo_flag_q;

endmodule

// File: tb/tb_nou_wr_arb_ctl.sv
module tb_nou_wr_arb_ctl;

   localparam int unsigned NREQ  = 4;
   localparam int unsigned HDR_W = 3;
   localparam int unsigned DAT_W = 12;
   localparam int unsigned TMO   = 16;

   logic                       clk;
   logic                       rstn;
   logic [NREQ-1:0]            req;
   logic [NREQ-1:0][HDR_W-1:0] req_hdr_num;
   logic [NREQ-1:0][DAT_W-1:0] req_dat_num;
   logic [NREQ-1:0]            gnt;
   logic [NREQ-1:0]            done;
   logic [NREQ-1:0]            err;
   logic                       wr_start;
   logic [HDR_W-1:0]           wr_hdr_num;
   logic [DAT_W-1:0]           wr_dat_num;
   logic                       wr_done;
   logic                       wr_err;
   logic                       tmo_flag;

   nou_wr_arb_ctl #(
      .NREQ  (NREQ),
      .HDR_W (HDR_W),
      .DAT_W (DAT_W),
      .TMO   (TMO)
   ) dut (
      .clk         (clk),
      .rstn        (rstn),
      .req         (req),
      .req_hdr_num (req_hdr_num),
      .req_dat_num (req_dat_num),
      .gnt         (gnt),
      .done        (done),
      .err         (err),
      .wr_start    (wr_start),
      .wr_hdr_num  (wr_hdr_num),
      .wr_dat_num  (wr_dat_num),
      .wr_done     (wr_done),
      .wr_err      (wr_err),
      .tmo_flag    (tmo_flag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // resp: 0 = done, 1 = err, 2 = err+done together, 3 = no response (timeout)
   typedef struct {
      logic [NREQ-1:0]  req;
      logic [HDR_W-1:0] hdr;
      logic [DAT_W-1:0] dat;
      int               delay;
      int               resp;
      int               exp_idx;
   } vec_t;

   vec_t tbl[11];
   int   errors;
   int   checks;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_vec(input vec_t v);
      logic [NREQ-1:0] oh;
      logic            zero;
      oh   = 4'b0001 << v.exp_idx;
      zero = (v.hdr == 0) && (v.dat == 0);
      req  = v.req;
      for (int i = 0; i < int'(NREQ); i++) begin
         if (i == v.exp_idx) begin
            req_hdr_num[i] = v.hdr;
            req_dat_num[i] = v.dat;
         end else begin
            req_hdr_num[i] = 3'd5;
            req_dat_num[i] = 12'hA5A;
         end
      end
      #1;
      check("idle_quiet", 32'({gnt, done, err, wr_start}), 32'd0);
      tick();
      check("start_gnt", 32'(gnt), 32'(oh));
      check("start_wr_start", 32'(wr_start), 32'(!zero));
      check("start_err", 32'(err), zero ? 32'(oh) : 32'd0);
      check("start_done", 32'(done), 32'd0);
      check("start_nums", 32'({wr_hdr_num, wr_dat_num}), 32'({v.hdr, v.dat}));
      if (zero) begin
         tick();
         check("reject_idle", 32'({gnt, done, err, wr_start, wr_hdr_num, wr_dat_num}), 32'd0);
         return;
      end
      for (int c = 0; c < v.delay; c++) begin
         tick();
         check("wait_quiet", 32'({gnt, done, err, wr_start}), 32'd0);
         check("wait_nums", 32'({wr_hdr_num, wr_dat_num}), 32'({v.hdr, v.dat}));
      end
      tick();
      wr_done = (v.resp == 0) || (v.resp == 2);
      wr_err  = (v.resp == 1) || (v.resp == 2);
      #1;
      check("resp_done", 32'(done), (v.resp == 0) ? 32'(oh) : 32'd0);
      check("resp_err", 32'(err), (v.resp != 0) ? 32'(oh) : 32'd0);
      check("resp_gnt_start", 32'({gnt, wr_start}), 32'd0);
      tick();
      wr_done = 1'b0;
      wr_err  = 1'b0;
      #1;
      check("exit_idle", 32'({gnt, done, err, wr_start, wr_hdr_num, wr_dat_num}), 32'd0);
      if (v.resp == 3) begin
         check("tmo_flag_set", 32'(tmo_flag), 32'd1);
      end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      //          req      hdr   dat      dly resp idx
      tbl[0]  = '{4'b0100, 3'd1, 12'd3,    9,  0,  2};  // single request, rr_ptr -> 3
      tbl[1]  = '{4'b1111, 3'd2, 12'd5,    0,  0,  3};  // pointer at 3 picks 3
      tbl[2]  = '{4'b1111, 3'd3, 12'd1,    2,  1,  0};  // wrap 3 -> 0, err response
      tbl[3]  = '{4'b1111, 3'd4, 12'd2,    1,  2,  1};  // err+done together: err wins
      tbl[4]  = '{4'b1111, 3'd1, 12'd0,    3,  0,  2};  // dat=0 alone is not a reject
      tbl[5]  = '{4'b1111, 3'd0, 12'd7,    0,  0,  3};  // hdr=0 alone is not a reject
      tbl[6]  = '{4'b1111, 3'd5, 12'd5,    0,  0,  0};  // second wrap
      tbl[7]  = '{4'b0011, 3'd0, 12'd0,    0,  0,  1};  // zero-count reject
      tbl[8]  = '{4'b0001, 3'd2, 12'd2,   15,  3,  0};  // ptr 2 wraps to 0; timeout
      tbl[9]  = '{4'b1000, 3'd7, 12'hFFF,  4,  0,  3};  // maximal counts, no overflow
      tbl[10] = '{4'b0010, 3'd1, 12'd1,    0,  0,  1};  // leaves rr_ptr at 2

      rstn        = 1'b0;
      req         = '0;
      req_hdr_num = '0;
      req_dat_num = '0;
      wr_done     = 1'b1;
      wr_err      = 1'b1;
      repeat (3) tick();
      check("rst_outputs", 32'({gnt, done, err, wr_start, wr_hdr_num, wr_dat_num}), 32'd0);
      check("rst_tmo_flag", 32'(tmo_flag), 32'd0);

      rstn = 1'b1;
      tick();
      check("idle_resp_ignored", 32'({done, err}), 32'd0);
      wr_done = 1'b0;
      wr_err  = 1'b0;
      tick();
      check("idle_stays_idle", 32'({gnt, wr_start}), 32'd0);

      for (int i = 0; i < 11; i++) begin
         run_vec(tbl[i]);
      end
      check("tmo_flag_sticky", 32'(tmo_flag), 32'd1);

      // Reset while waiting: transaction dropped, pointer returns to 0.
      req            = 4'b0100;
      req_hdr_num[2] = 3'd2;
      req_dat_num[2] = 12'd6;
      tick();
      check("abort_gnt", 32'(gnt), 32'h4);
      tick();
      tick();
      rstn    = 1'b0;
      wr_done = 1'b1;
      #1;
      check("abort_outputs_now", 32'({gnt, done, err, wr_start, wr_hdr_num, wr_dat_num}), 32'd0);
      tick();
      check("abort_outputs_rst", 32'({gnt, done, err, wr_start, wr_hdr_num, wr_dat_num}), 32'd0);
      check("abort_tmo_cleared", 32'(tmo_flag), 32'd0);
      wr_done = 1'b0;
      rstn    = 1'b1;
      req     = 4'b1111;
      for (int i = 0; i < int'(NREQ); i++) begin
         req_hdr_num[i] = 3'd1;
         req_dat_num[i] = 12'd1;
      end
      #1;
      check("post_rst_idle", 32'({gnt, done, err}), 32'd0);
      tick();
      check("post_rst_gnt", 32'(gnt), 32'h1);
      check("post_rst_start", 32'(wr_start), 32'd1);
      req = '0;
      tick();
      wr_done = 1'b1;
      #1;
      check("post_rst_done", 32'(done), 32'h1);
      tick();
      wr_done = 1'b0;
      #1;
      check("post_rst_idle2", 32'({gnt, done, err, wr_start}), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
